gcd_miter_seq: RTL and testbench
================================

Name: gcd_miter_seq

Overview:
Test sequencer placed directly upstream of the two-implementation GCD miter. It generates operand pairs (LFSR or external directed), pulses the miter's active-low load strobe, and waits for both implementations to report valid. It then compares the two results and accumulates pass/fail/timeout statistics. It drives Ain/Bin/nstart of both GCD instances and consumes their Out/valid.

Parameters:
WIDTH, 6, operand/result width
NUM_TESTS, 16, operand pairs per run (>=1)
TIMEOUT, 255, max RUN cycles per test before declaring a hang (>=1)
SEED, 16'hACE1, 16-bit LFSR reset seed (nonzero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a run; sampled only in IDLE/DONE
mode_ext  in  1  1: operands from ext_a/ext_b; 0: LFSR
ext_a  in  WIDTH  directed operand A
ext_b  in  WIDTH  directed operand B
Ain  out  WIDTH  operand A to both GCD instances
Bin  out  WIDTH  operand B to both GCD instances
nstart  out  1  active-low load strobe to both instances
Out_1  in  WIDTH  result, implementation 1
Out_2  in  WIDTH  result, implementation 2
valid_1  in  1  result valid, implementation 1
valid_2  in  1  result valid, implementation 2
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion
test_count  out  CW  tests completed; CW = clog2(NUM_TESTS+1)
fail_count  out  CW  mismatches plus timeouts
timeout_seen  out  1  sticky: some test timed out this run
first_fail_a  out  WIDTH  Ain of first failing test
first_fail_b  out  WIDTH  Bin of first failing test

Behaviour:
- Reset (rst=1 at an edge): state IDLE. Ain=Bin=0, nstart=0, busy=0, done=0. Counters, timeout_seen, first_fail_* = 0. LFSR = SEED. Reset mid-run aborts immediately. No partial statistics are retained.
- nstart is 0 in IDLE, LOAD and DONE, so the GCD instances stay loaded with valid=0 while the block is quiescent. It is 1 only in RUN and CHECK.
- FSM:
  - IDLE: start=1 -> GEN. Clear counters, timeout_seen and first_fail_*. busy=1 from the next cycle.
  - GEN (1 cycle): select operands. ext_a/ext_b if mode_ext, else LFSR bits [WIDTH-1:0] and [2*WIDTH-1:WIDTH] after one LFSR step. Any zero operand is replaced by 1, because zero operands make the subtractive GCD loop forever. Register into Ain/Bin -> LOAD.
  - LOAD (1 cycle): nstart=0, Ain/Bin stable -> RUN. Clear the timeout counter.
  - RUN: nstart=1. Ain/Bin are held constant.
    - valid_1 & valid_2 -> CHECK.
    - Otherwise, if the timeout counter reaches TIMEOUT -> CHECK with a hang flag. Otherwise increment the counter.
    - Valids are not sampled before the first RUN cycle.
  - CHECK (1 cycle): fail if hang or Out_1 != Out_2. test_count++. On fail: fail_count++, and timeout_seen |= hang.
    - On the first fail only, capture Ain/Bin into first_fail_*.
    - If test_count (pre-increment) == NUM_TESTS-1 -> DONE, else -> GEN.
  - DONE: busy=0. done=1 for exactly the entry cycle. Statistics are held. start=1 -> GEN (new run, statistics cleared).
- start is ignored while busy.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps only in GEN and never reaches zero. For WIDTH>8, operands are taken from two consecutive steps.
- Latency per test: GEN+LOAD+CHECK = 3 cycles, plus RUN cycles until both valids are seen.
- Counters saturate at NUM_TESTS; no wrap.

Decomposition:
- Package gcd_miter_pkg: FSM state enum (IDLE, GEN, LOAD, RUN, CHECK, DONE), LFSR tap constant, nz() function (zero -> 1).
- One sub-module, gcd_opgen_lfsr: step enable, seed load on reset, two WIDTH-bit nonzero operands out.

Test Plan:
- NUM_TESTS=1, mode_ext=1, ext 12/18, behavioural DUTs both return 6 -> done pulse, test_count=1, fail_count=0, timeout_seen=0, nstart low for exactly 1 cycle after GEN.
- NUM_TESTS=1, ext 12/18, model 2 returns 7 -> fail_count=1, first_fail_a=12, first_fail_b=18, timeout_seen=0.
- TIMEOUT=10, valid_2 held 0 -> CHECK after 11 RUN cycles, fail_count=1, timeout_seen=1, done asserted.
- mode_ext=1, ext 0/9 -> Ain=1, Bin=9 during LOAD; both models return 1; fail_count=0.
- NUM_TESTS=16, LFSR mode, real fast/slow GCD instances -> test_count=16, fail_count=0, all Ain/Bin nonzero, start pulses while busy ignored.
- rst asserted in the 3rd RUN cycle -> next cycle busy=0, nstart=0, counters=0; a subsequent start reproduces the first LFSR operands from SEED.

Source files
------------

// File: rtl/gcd_miter_pkg.sv
// Shared definitions for the GCD miter test sequencer.
// Contents:
//   state_e    - sequencer FSM states
//   LFSR_TAPS  - feedback mask of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   lfsr_step  - one LFSR shift
//   nz         - maps a zero operand to 1 (zero makes a subtractive GCD spin forever)
package gcd_miter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Operands narrower than 16 bits are zero-extended before the call, so the
    // zero test covers exactly the operand bits.
    function automatic logic [15:0] nz(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/gcd_opgen_lfsr.sv
// Pseudo-random operand generator for the GCD miter sequencer.
// A 16-bit Fibonacci LFSR advances when step=1 and yields two nonzero
// WIDTH-bit operands taken from the advanced value (WIDTH <= 16).
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset (loads SEED)
//   step       - advance the LFSR at this edge
//   op_a, op_b - operands derived from the next LFSR state (never zero)
module gcd_opgen_lfsr
    import gcd_miter_pkg::*;
#(
    parameter int          WIDTH = 6,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b
);

    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nxt_s;
    logic [WIDTH-1:0] raw_a_s;
    logic [WIDTH-1:0] raw_b_s;

    generate
        if (WIDTH <= 8) begin : g_one_step
            // Both operands fit in one advanced LFSR word.
            always_comb begin
                lfsr_nxt_s = lfsr_step(lfsr_r);
                raw_a_s    = lfsr_nxt_s[WIDTH-1:0];
                raw_b_s    = lfsr_nxt_s[2*WIDTH-1:WIDTH];
            end
        end else begin : g_two_step
            logic [15:0] mid_s;
            // Wide operands: A from the first step, B from the second.
            always_comb begin
                mid_s      = lfsr_step(lfsr_r);
                lfsr_nxt_s = lfsr_step(mid_s);
                raw_a_s    = mid_s[WIDTH-1:0];
                raw_b_s    = lfsr_nxt_s[WIDTH-1:0];
            end
        end
    endgenerate

    // Zero operands are forced to 1 before leaving the generator.
    always_comb begin
        op_a = WIDTH'(nz(16'(raw_a_s)));
        op_b = WIDTH'(nz(16'(raw_b_s)));
    end

    // LFSR state register; a nonzero seed keeps it out of the all-zero lockup.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else if (step) begin
            lfsr_r <= lfsr_nxt_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/gcd_miter_seq.sv
// Test sequencer driving both GCD implementations of a miter.
// Per test it selects operands (directed or LFSR), holds the shared load strobe
// low for one LOAD cycle, waits for both valids (or a timeout), compares results
// and accumulates run statistics.
// Ports:
//   clk, rst                 - rising-edge clock, synchronous active-high reset
//   start                    - begin a run (honoured only in IDLE/DONE)
//   mode_ext, ext_a, ext_b   - 1: use ext_a/ext_b as operands, 0: use LFSR
//   Ain, Bin, nstart         - operands and active-low load strobe to both GCDs
//   Out_1/Out_2, valid_1/2   - results from the two implementations
//   busy, done               - run in progress / one-cycle completion pulse
//   test_count, fail_count   - tests completed / mismatches plus timeouts
//   timeout_seen             - sticky: a test hung during this run
//   first_fail_a/b           - operands of the first failing test
module gcd_miter_seq
    import gcd_miter_pkg::*;
#(
    parameter int          WIDTH     = 6,
    parameter int          NUM_TESTS = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         CW        = $clog2(NUM_TESTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_ext,
    input  logic [WIDTH-1:0] ext_a,
    input  logic [WIDTH-1:0] ext_b,
    output logic [WIDTH-1:0] Ain,
    output logic [WIDTH-1:0] Bin,
    output logic             nstart,
    input  logic [WIDTH-1:0] Out_1,
    input  logic [WIDTH-1:0] Out_2,
    input  logic             valid_1,
    input  logic             valid_2,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    test_count,
    output logic [CW-1:0]    fail_count,
    output logic             timeout_seen,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_r;
    state_e           state_nxt_s;

    logic [WIDTH-1:0] ain_r;
    logic [WIDTH-1:0] bin_r;
    logic             nstart_r;
    logic             busy_r;
    logic             done_r;
    logic [CW-1:0]    test_cnt_r;
    logic [CW-1:0]    fail_cnt_r;
    logic             tmo_seen_r;
    logic [WIDTH-1:0] ff_a_r;
    logic [WIDTH-1:0] ff_b_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic             hang_r;

    logic             clr_stats_s;
    logic             gen_s;
    logic             clr_tmo_s;
    logic             inc_tmo_s;
    logic             set_hang_s;
    logic             check_s;
    logic             fail_s;
    logic [WIDTH-1:0] lfsr_a_s;
    logic [WIDTH-1:0] lfsr_b_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    gcd_opgen_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_opgen (
        .clk   (clk),
        .rst   (rst),
        .step  (gen_s),
        .op_a  (lfsr_a_s),
        .op_b  (lfsr_b_s)
    );

    // Next-state logic and per-state datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        clr_stats_s = 1'b0;
        gen_s       = 1'b0;
        clr_tmo_s   = 1'b0;
        inc_tmo_s   = 1'b0;
        set_hang_s  = 1'b0;
        check_s     = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = GEN;
                    clr_stats_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            GEN: begin
                gen_s       = 1'b1;
                state_nxt_s = LOAD;
            end
            LOAD: begin
                clr_tmo_s   = 1'b1;
                state_nxt_s = RUN;
            end
            RUN: begin
                if (valid_1 && valid_2) begin
                    state_nxt_s = CHECK;
                end else if (tmo_cnt_r == TW'(TIMEOUT)) begin
                    state_nxt_s = CHECK;
                    set_hang_s  = 1'b1;
                end else begin
                    inc_tmo_s   = 1'b1;
                end
            end
            CHECK: begin
                check_s = 1'b1;
                if (test_cnt_r == CW'(NUM_TESTS - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand source select; directed operands get the same zero fix as LFSR ones.
    always_comb begin
        if (mode_ext) begin
            sel_a_s = WIDTH'(nz(16'(ext_a)));
            sel_b_s = WIDTH'(nz(16'(ext_b)));
        end else begin
            sel_a_s = lfsr_a_s;
            sel_b_s = lfsr_b_s;
        end
    end

    // A hang counts as a failure regardless of whatever the outputs show.
    always_comb begin
        fail_s = hang_r | (Out_1 != Out_2);
    end

    // State register and control outputs, registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            nstart_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            nstart_r <= (state_nxt_s == RUN) || (state_nxt_s == CHECK);
            busy_r   <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
            done_r   <= (state_nxt_s == DONE) && (state_r != DONE);
        end
    end

    // Operand registers: written in GEN, held through LOAD/RUN/CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            ain_r <= {WIDTH{1'b0}};
            bin_r <= {WIDTH{1'b0}};
        end else if (gen_s) begin
            ain_r <= sel_a_s;
            bin_r <= sel_b_s;
        end else begin
            ain_r <= ain_r;
            bin_r <= bin_r;
        end
    end

    // Per-test RUN cycle counter and hang flag, both cleared in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TW{1'b0}};
            hang_r    <= 1'b0;
        end else if (clr_tmo_s) begin
            tmo_cnt_r <= {TW{1'b0}};
            hang_r    <= 1'b0;
        end else if (inc_tmo_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
            hang_r    <= hang_r;
        end else if (set_hang_s) begin
            tmo_cnt_r <= tmo_cnt_r;
            hang_r    <= 1'b1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
            hang_r    <= hang_r;
        end
    end

    // Run statistics: cleared on start, updated once per test in CHECK.
    always_ff @(posedge clk) begin
        if (rst || clr_stats_s) begin
            test_cnt_r <= {CW{1'b0}};
            fail_cnt_r <= {CW{1'b0}};
            tmo_seen_r <= 1'b0;
            ff_a_r     <= {WIDTH{1'b0}};
            ff_b_r     <= {WIDTH{1'b0}};
        end else if (check_s) begin
            if (test_cnt_r != CW'(NUM_TESTS)) begin
                test_cnt_r <= test_cnt_r + CW'(1);
            end else begin
                test_cnt_r <= test_cnt_r;
            end
            if (fail_s) begin
                if (fail_cnt_r != CW'(NUM_TESTS)) begin
                    fail_cnt_r <= fail_cnt_r + CW'(1);
                end else begin
                    fail_cnt_r <= fail_cnt_r;
                end
                tmo_seen_r <= tmo_seen_r | hang_r;
                // fail_cnt_r saturates rather than wraps, so zero means "no fail yet".
                if (fail_cnt_r == {CW{1'b0}}) begin
                    ff_a_r <= ain_r;
                    ff_b_r <= bin_r;
                end else begin
                    ff_a_r <= ff_a_r;
                    ff_b_r <= ff_b_r;
                end
            end else begin
                fail_cnt_r <= fail_cnt_r;
                tmo_seen_r <= tmo_seen_r;
                ff_a_r     <= ff_a_r;
                ff_b_r     <= ff_b_r;
            end
        end else begin
            test_cnt_r <= test_cnt_r;
            fail_cnt_r <= fail_cnt_r;
            tmo_seen_r <= tmo_seen_r;
            ff_a_r     <= ff_a_r;
            ff_b_r     <= ff_b_r;
        end
    end

    assign Ain          = ain_r;
    assign Bin          = bin_r;
    assign nstart       = nstart_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign test_count   = test_cnt_r;
    assign fail_count   = fail_cnt_r;
    assign timeout_seen = tmo_seen_r;
    assign first_fail_a = ff_a_r;
    assign first_fail_b = ff_b_r;

endmodule

// File: tb/tb_gcd_miter_seq.sv
// Directed bench for gcd_miter_seq. dut_a: NUM_TESTS=1, TIMEOUT=10, directed
// operands, with result/valid overrides on its second GCD model. dut_b:
// NUM_TESTS=16, LFSR operands, fast (modulo) and slow (subtractive) models.
module tb_gcd_miter_seq;

    localparam int W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_v   [2];
    logic         start_v [2];
    logic         mode_v  [2];
    logic [W-1:0] exta_v  [2];
    logic [W-1:0] extb_v  [2];
    logic [W-1:0] ain_v   [2];
    logic [W-1:0] bin_v   [2];
    logic         nst_v   [2];
    logic [W-1:0] out1_v  [2];
    logic [W-1:0] out2_v  [2];
    logic         val1_v  [2];
    logic         val2_v  [2];
    logic         busy_v  [2];
    logic         done_v  [2];
    logic         tseen_v [2];
    logic [W-1:0] ffa_v   [2];
    logic [W-1:0] ffb_v   [2];
    logic [0:0]   tc_a, fc_a;
    logic [4:0]   tc_b, fc_b;

    // GCD models: 0 = dut_a fast, 1 = dut_a slow, 2 = dut_b fast, 3 = dut_b slow.
    logic [W-1:0] mx [4];
    logic [W-1:0] my [4];
    logic         mval [4];
    logic         frc_en;
    logic [W-1:0] frc_val;
    logic         kill_v2;

    int passed = 0;
    int total  = 0;

    always_ff @(posedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (!nst_v[m/2]) begin
                mx[m] <= ain_v[m/2];
                my[m] <= bin_v[m/2];
            end else if (mx[m] > my[m]) begin
                if (m % 2 == 0) mx[m] <= ((mx[m] % my[m]) == 6'd0) ? my[m] : (mx[m] % my[m]);
                else            mx[m] <= mx[m] - my[m];
            end else if (my[m] > mx[m]) begin
                if (m % 2 == 0) my[m] <= ((my[m] % mx[m]) == 6'd0) ? mx[m] : (my[m] % mx[m]);
                else            my[m] <= my[m] - mx[m];
            end
        end
    end

    always_comb begin
        for (int m = 0; m < 4; m++) mval[m] = nst_v[m/2] && (mx[m] == my[m]);
    end

    assign out1_v[0] = mx[0];
    assign val1_v[0] = mval[0];
    assign out2_v[0] = frc_en ? frc_val : mx[1];
    assign val2_v[0] = kill_v2 ? 1'b0 : mval[1];
    assign out1_v[1] = mx[2];
    assign val1_v[1] = mval[2];
    assign out2_v[1] = mx[3];
    assign val2_v[1] = mval[3];

    gcd_miter_seq #(.WIDTH(W), .NUM_TESTS(1), .TIMEOUT(10), .SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .mode_ext(mode_v[0]),
        .ext_a(exta_v[0]), .ext_b(extb_v[0]), .Ain(ain_v[0]), .Bin(bin_v[0]),
        .nstart(nst_v[0]), .Out_1(out1_v[0]), .Out_2(out2_v[0]),
        .valid_1(val1_v[0]), .valid_2(val2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .test_count(tc_a), .fail_count(fc_a), .timeout_seen(tseen_v[0]),
        .first_fail_a(ffa_v[0]), .first_fail_b(ffb_v[0]));

    gcd_miter_seq #(.WIDTH(W), .NUM_TESTS(16), .TIMEOUT(255), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .mode_ext(mode_v[1]),
        .ext_a(exta_v[1]), .ext_b(extb_v[1]), .Ain(ain_v[1]), .Bin(bin_v[1]),
        .nstart(nst_v[1]), .Out_1(out1_v[1]), .Out_2(out2_v[1]),
        .valid_1(val1_v[1]), .valid_2(val2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .test_count(tc_b), .fail_count(fc_b), .timeout_seen(tseen_v[1]),
        .first_fail_a(ffa_v[1]), .first_fail_b(ffb_v[1]));

    // Raise start for one cycle on DUT d.
    task automatic kick(input int d);
        @(negedge clk);
        start_v[d] = 1'b1;
    endtask

    // Observe DUT d at each negedge until two cycles after done (or bound).
    // Optionally pulses start while busy. Records done pulses, busy cycles with
    // nstart low/high, zero operands during RUN/CHECK, and first LOAD operands.
    task automatic watch(input int d, input int bound, input bit pulse,
                         output int done_cnt, output int nlow, output int nhigh,
                         output int zero_ops, output logic [W-1:0] la, output logic [W-1:0] lb);
        int  after;
        bit  prev_low;
        bit  got_load;
        done_cnt = 0; nlow = 0; nhigh = 0; zero_ops = 0;
        la = '0; lb = '0; after = -1; prev_low = 1'b0; got_load = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            start_v[d] = (pulse && busy_v[d] && (c % 7 == 3)) ? 1'b1 : 1'b0;
            if (busy_v[d] && !nst_v[d]) begin
                nlow++;
                if (prev_low && !got_load) begin
                    la = ain_v[d]; lb = bin_v[d]; got_load = 1'b1;
                end
                prev_low = 1'b1;
            end else begin
                prev_low = 1'b0;
            end
            if (busy_v[d] && nst_v[d]) begin
                nhigh++;
                if (ain_v[d] == '0 || bin_v[d] == '0) zero_ops++;
            end
            if (done_v[d]) begin
                done_cnt++;
                if (after < 0) after = 3;
            end
            if (after > 0) begin
                after--;
                if (after == 0) break;
            end
        end
        start_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy_v[0] !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", busy_v[0]); else passed++;
        total++; if (nst_v[0] !== 1'b0) $display("FAIL reset_nstart_a: got %b want 0", nst_v[0]); else passed++;
        total++; if (done_v[0] !== 1'b0) $display("FAIL reset_done_a: got %b want 0", done_v[0]); else passed++;
        total++; if (ain_v[0] !== 6'd0 || bin_v[0] !== 6'd0) $display("FAIL reset_ops_a: got %0d/%0d want 0/0", ain_v[0], bin_v[0]); else passed++;
        total++; if (tc_a !== 1'b0 || fc_a !== 1'b0) $display("FAIL reset_counts_a: got %0d/%0d want 0/0", tc_a, fc_a); else passed++;
        total++; if (tseen_v[0] !== 1'b0 || ffa_v[0] !== 6'd0) $display("FAIL reset_stats_a: got %b/%0d want 0/0", tseen_v[0], ffa_v[0]); else passed++;
        total++; if (busy_v[1] !== 1'b0 || nst_v[1] !== 1'b0) $display("FAIL reset_ctrl_b: got %b/%b want 0/0", busy_v[1], nst_v[1]); else passed++;
        total++; if (tc_b !== 5'd0 || fc_b !== 5'd0) $display("FAIL reset_counts_b: got %0d/%0d want 0/0", tc_b, fc_b); else passed++;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
    endtask

    task automatic test_pass_ext();
        int dc, nl, nh, zo; logic [W-1:0] la, lb;
        mode_v[0] = 1'b1; exta_v[0] = 6'd12; extb_v[0] = 6'd18;
        kick(0);
        watch(0, 200, 1'b0, dc, nl, nh, zo, la, lb);
        total++; if (dc !== 1) $display("FAIL pass_done_pulse: got %0d want 1", dc); else passed++;
        total++; if (nl !== 2) $display("FAIL pass_nstart_low_cycles: got %0d want 2", nl); else passed++;
        // 12/18: two model steps, valid seen in the third RUN cycle, then CHECK.
        total++; if (nh !== 4) $display("FAIL pass_run_check_cycles: got %0d want 4", nh); else passed++;
        total++; if (la !== 6'd12 || lb !== 6'd18) $display("FAIL pass_load_ops: got %0d/%0d want 12/18", la, lb); else passed++;
        total++; if (tc_a !== 1'b1) $display("FAIL pass_test_count: got %0d want 1", tc_a); else passed++;
        total++; if (fc_a !== 1'b0) $display("FAIL pass_fail_count: got %0d want 0", fc_a); else passed++;
        total++; if (tseen_v[0] !== 1'b0) $display("FAIL pass_timeout_seen: got %b want 0", tseen_v[0]); else passed++;
        total++; if (busy_v[0] !== 1'b0) $display("FAIL pass_busy_after: got %b want 0", busy_v[0]); else passed++;
    endtask

    task automatic test_mismatch();
        int dc, nl, nh, zo; logic [W-1:0] la, lb;
        frc_en = 1'b1; frc_val = 6'd7;
        kick(0);
        watch(0, 200, 1'b0, dc, nl, nh, zo, la, lb);
        frc_en = 1'b0;
        total++; if (dc !== 1) $display("FAIL mism_done_pulse: got %0d want 1", dc); else passed++;
        total++; if (fc_a !== 1'b1) $display("FAIL mism_fail_count: got %0d want 1", fc_a); else passed++;
        total++; if (tc_a !== 1'b1) $display("FAIL mism_test_count: got %0d want 1", tc_a); else passed++;
        total++; if (ffa_v[0] !== 6'd12 || ffb_v[0] !== 6'd18) $display("FAIL mism_first_fail: got %0d/%0d want 12/18", ffa_v[0], ffb_v[0]); else passed++;
        total++; if (tseen_v[0] !== 1'b0) $display("FAIL mism_timeout_seen: got %b want 0", tseen_v[0]); else passed++;
    endtask

    task automatic test_timeout();
        int dc, nl, nh, zo; logic [W-1:0] la, lb;
        kill_v2 = 1'b1;
        kick(0);
        watch(0, 200, 1'b0, dc, nl, nh, zo, la, lb);
        kill_v2 = 1'b0;
        total++; if (dc !== 1) $display("FAIL tmo_done_pulse: got %0d want 1", dc); else passed++;
        // TIMEOUT=10: eleven RUN cycles, then one CHECK cycle.
        total++; if (nh !== 12) $display("FAIL tmo_run_check_cycles: got %0d want 12", nh); else passed++;
        total++; if (fc_a !== 1'b1) $display("FAIL tmo_fail_count: got %0d want 1", fc_a); else passed++;
        total++; if (tseen_v[0] !== 1'b1) $display("FAIL tmo_timeout_seen: got %b want 1", tseen_v[0]); else passed++;
        total++; if (ffa_v[0] !== 6'd12 || ffb_v[0] !== 6'd18) $display("FAIL tmo_first_fail: got %0d/%0d want 12/18", ffa_v[0], ffb_v[0]); else passed++;
    endtask

    task automatic test_zero_operand();
        int dc, nl, nh, zo; logic [W-1:0] la, lb;
        exta_v[0] = 6'd0; extb_v[0] = 6'd9;
        kick(0);
        watch(0, 200, 1'b0, dc, nl, nh, zo, la, lb);
        total++; if (la !== 6'd1 || lb !== 6'd9) $display("FAIL zero_load_ops: got %0d/%0d want 1/9", la, lb); else passed++;
        total++; if (dc !== 1) $display("FAIL zero_done_pulse: got %0d want 1", dc); else passed++;
        total++; if (fc_a !== 1'b0 || tc_a !== 1'b1) $display("FAIL zero_counts: got fail %0d tests %0d want 0/1", fc_a, tc_a); else passed++;
        total++; if (ffa_v[0] !== 6'd0 || tseen_v[0] !== 1'b0) $display("FAIL zero_stats_cleared: got %0d/%b want 0/0", ffa_v[0], tseen_v[0]); else passed++;
    endtask

    // First LFSR step from 16'hACE1 gives 16'h59C3: A = bits[5:0] = 3, B = bits[11:6] = 39.
    task automatic test_lfsr_run();
        int dc, nl, nh, zo; logic [W-1:0] la, lb;
        mode_v[1] = 1'b0;
        kick(1);
        watch(1, 4000, 1'b1, dc, nl, nh, zo, la, lb);
        total++; if (dc !== 1) $display("FAIL lfsr_done_pulse: got %0d want 1", dc); else passed++;
        total++; if (la !== 6'd3 || lb !== 6'd39) $display("FAIL lfsr_first_ops: got %0d/%0d want 3/39", la, lb); else passed++;
        total++; if (tc_b !== 5'd16) $display("FAIL lfsr_test_count: got %0d want 16", tc_b); else passed++;
        total++; if (fc_b !== 5'd0) $display("FAIL lfsr_fail_count: got %0d want 0", fc_b); else passed++;
        total++; if (nl !== 32) $display("FAIL lfsr_nstart_low_cycles: got %0d want 32", nl); else passed++;
        total++; if (zo !== 0) $display("FAIL lfsr_zero_operands: got %0d want 0", zo); else passed++;
        total++; if (tseen_v[1] !== 1'b0 || busy_v[1] !== 1'b0) $display("FAIL lfsr_end_state: got tmo %b busy %b want 0/0", tseen_v[1], busy_v[1]); else passed++;
    endtask

    task automatic test_reset_midrun();
        int dc, nl, nh, zo, runs; logic [W-1:0] la, lb;
        runs = 0;
        kick(1);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
            if (busy_v[1] && nst_v[1]) runs++;
            if (runs == 3) break;
        end
        total++; if (runs !== 3) $display("FAIL midrun_reach_run: got %0d want 3", runs); else passed++;
        rst_v[1] = 1'b1;
        @(negedge clk);
        total++; if (busy_v[1] !== 1'b0 || nst_v[1] !== 1'b0) $display("FAIL midrun_ctrl: got busy %b nstart %b want 0/0", busy_v[1], nst_v[1]); else passed++;
        total++; if (tc_b !== 5'd0 || fc_b !== 5'd0) $display("FAIL midrun_counts: got %0d/%0d want 0/0", tc_b, fc_b); else passed++;
        total++; if (ain_v[1] !== 6'd0 || bin_v[1] !== 6'd0) $display("FAIL midrun_ops: got %0d/%0d want 0/0", ain_v[1], bin_v[1]); else passed++;
        rst_v[1] = 1'b0;
        kick(1);
        watch(1, 4000, 1'b0, dc, nl, nh, zo, la, lb);
        total++; if (la !== 6'd3 || lb !== 6'd39) $display("FAIL midrun_reseed_ops: got %0d/%0d want 3/39", la, lb); else passed++;
        total++; if (dc !== 1 || tc_b !== 5'd16) $display("FAIL midrun_rerun: got done %0d tests %0d want 1/16", dc, tc_b); else passed++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1; start_v[d] = 1'b0; mode_v[d] = 1'b0;
            exta_v[d] = 6'd0; extb_v[d] = 6'd0;
        end
        frc_en = 1'b0; frc_val = 6'd0; kill_v2 = 1'b0;
        test_reset();
        test_pass_ext();
        test_mismatch();
        test_timeout();
        test_zero_operand();
        test_lfsr_run();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
